// File: rtl/wb_sram_burst_slave_if.sv
// Wishbone B4 bus bundle shared by the SRAM burst slave and its masters.
interface wb_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   adr;
  logic [2:0]              cti;
  logic [1:0]              bte;
  logic [DATA_WIDTH-1:0]   dat_w;
  logic [DATA_WIDTH-1:0]   dat_r;
  logic [DATA_WIDTH/8-1:0] sel;
  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic                    ack;
  logic                    err;

  modport slave (
    input  adr, cti, bte, dat_w, sel, cyc, stb, we,
    output dat_r, ack, err
  );

  modport master (
    output adr, cti, bte, dat_w, sel, cyc, stb, we,
    input  dat_r, ack, err
  );
endinterface

// File: rtl/wb_sram_burst_slave.sv
// Wishbone B4 slave fronting a 1-cycle-latency synchronous SRAM; classic and incrementing bursts.
// Optional WB_SRAM_RANGE_ERR_EN: out-of-window requests are answered with a one-cycle ERR.
module wb_sram_burst_slave #(
  parameter int unsigned              WB_ADDR_WIDTH  = 32,
  parameter int unsigned              WB_DATA_WIDTH  = 32,
  parameter int unsigned              MEM_ADDR_WIDTH = 10,
  parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
  input  logic                       clk,
  input  logic                       rstn,
  wb_if.slave                        s,
  output logic                       mem_cs,
  output logic                       mem_we,
  output logic [MEM_ADDR_WIDTH-1:0]  mem_addr,
  output logic [WB_DATA_WIDTH/8-1:0] mem_be,
  output logic [WB_DATA_WIDTH-1:0]   mem_wdata,
  input  logic [WB_DATA_WIDTH-1:0]   mem_rdata
);

  localparam int unsigned OFS = $clog2(WB_DATA_WIDTH / 8);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACT  = 2'd1;
`ifdef WB_SRAM_RANGE_ERR_EN
  localparam logic [1:0] ERRS = 2'd2;
  localparam logic [WB_ADDR_WIDTH:0] LIMIT =
    {1'b0, BASE_ADDR} + ((WB_ADDR_WIDTH + 1)'(1) << (MEM_ADDR_WIDTH + OFS));
`endif

  logic [1:0]                state;
  logic [MEM_ADDR_WIDTH-1:0] addr_cnt;
  logic [MEM_ADDR_WIDTH-1:0] addr_nxt;
  logic [MEM_ADDR_WIDTH-1:0] wrap_mask;
  logic [MEM_ADDR_WIDTH-1:0] index;
  logic                      we_q;
  logic                      req;
  logic                      cont;
  logic                      start_ok;

  assign req   = s.cyc & s.stb;
  assign cont  = req & (s.cti == 3'b010);
  assign index = MEM_ADDR_WIDTH'((s.adr - BASE_ADDR) >> OFS);

`ifdef WB_SRAM_RANGE_ERR_EN
  logic range_err;
  assign range_err = (s.adr < BASE_ADDR) || ({1'b0, s.adr} >= LIMIT);
  assign start_ok  = req & ~range_err;
`else
  assign start_ok  = req;
`endif

  // Wrap bursts only advance the low address bits; linear uses an all-ones mask.
  always_comb begin
    case (s.bte)
      2'b01:   wrap_mask = MEM_ADDR_WIDTH'(3);
      2'b10:   wrap_mask = MEM_ADDR_WIDTH'(7);
      2'b11:   wrap_mask = MEM_ADDR_WIDTH'(15);
      default: wrap_mask = '1;
    endcase
    addr_nxt = (addr_cnt & ~wrap_mask) | ((addr_cnt + MEM_ADDR_WIDTH'(1)) & wrap_mask);
  end

  always_comb begin
    s.ack     = 1'b0;
    s.err     = 1'b0;
    s.dat_r   = '0;
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    if (rstn) begin
      case (state)
        IDLE: begin
          if (start_ok && !s.we) begin
            mem_cs   = 1'b1;
            mem_addr = index;
          end
        end
        ACT: begin
          if (req) begin
            s.ack = 1'b1;
            if (we_q) begin
              mem_cs    = 1'b1;
              mem_we    = 1'b1;
              mem_addr  = addr_cnt;
              mem_be    = s.sel;
              mem_wdata = s.dat_w;
            end else begin
              s.dat_r = mem_rdata;
              // Prefetch the following beat so the burst sustains one ACK per clock.
              if (cont) begin
                mem_cs   = 1'b1;
                mem_addr = addr_nxt;
              end
            end
          end
        end
`ifdef WB_SRAM_RANGE_ERR_EN
        ERRS: s.err = req;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      addr_cnt <= '0;
      we_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            addr_cnt <= index;
            we_q     <= s.we;
`ifdef WB_SRAM_RANGE_ERR_EN
            state    <= range_err ? ERRS : ACT;
`else
            state    <= ACT;
`endif
          end
        end
        ACT: begin
          if (cont) addr_cnt <= addr_nxt;
          else      state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/wb_sram_burst_slave.md
# wb_sram_burst_slave

Wishbone B4 slave that terminates one slave port of the Wishbone interconnect and fronts a single-port synchronous SRAM with one-cycle read latency. It supports classic single-beat cycles and registered-feedback incrementing bursts (CTI=010) with linear and wrap-4/8/16 addressing. After the first beat, a burst sustains one ACK per clock.

## Interface
- WB_ADDR_WIDTH, 32: Wishbone address width (byte address).
- WB_DATA_WIDTH, 32: Wishbone data width; multiple of 8.
- MEM_ADDR_WIDTH, 10: SRAM word-address width; capacity is 2^MEM_ADDR_WIDTH words.
- BASE_ADDR, 'h0: byte address that maps to SRAM word 0.

Ports:
- clk  input  1  clock; all state on rising edge.
- rstn  input  1  reset, asynchronous assert, active-low.
- s  wb_if.slave  WB_ADDR_WIDTH/WB_DATA_WIDTH  Wishbone slave port (ADR, CTI, BTE, DAT_W, DAT_R, CYC, ERR, SEL, STB, ACK, WE).
- mem_cs  output  1  SRAM access enable.
- mem_we  output  1  SRAM write enable (valid with mem_cs).
- mem_addr  output  MEM_ADDR_WIDTH  SRAM word address.
- mem_be  output  WB_DATA_WIDTH/8  byte enables (= SEL on writes).
- mem_wdata  output  WB_DATA_WIDTH  write data (= DAT_W).
- mem_rdata  input  WB_DATA_WIDTH  read data, valid the cycle after a read access.

## Operation
- Word index: (ADR − BASE_ADDR) >> log2(WB_DATA_WIDTH/8), truncated to MEM_ADDR_WIDTH bits.
- FSM states:
  - IDLE.
  - ACT: beat in progress, ACK asserted.
  - ERRS: only present with the macro in Configuration.
- Internal register addr_cnt (MEM_ADDR_WIDTH bits). WE is latched as we_q at start and ignored thereafter.
- IDLE, CYC&STB seen:
  - addr_cnt ← index; go to ACT.
  - Read: mem_cs=1, mem_we=0, mem_addr=index, driven combinationally in the same cycle.
  - Write: no memory access in IDLE.
- ACT:
  - ACK = CYC & STB.
  - Read: DAT_R = mem_rdata.
  - Write: mem_cs=1, mem_we=1, mem_addr=addr_cnt, mem_be=SEL, mem_wdata=DAT_W; the write commits on this edge.
  - Continue condition: CTI=010 & STB & CYC. When it holds:
    - addr_cnt ← next(addr_cnt); stay in ACT.
    - Reads also issue mem_cs=1 with mem_addr=next(addr_cnt) in this cycle (prefetch).
  - CTI=000 or 111 → IDLE after this beat.
  - STB=0 or CYC=0 in ACT → IDLE, no ACK, no memory write. Any prefetched read is discarded.
- next() by BTE:
  - 00: +1 modulo 2^MEM_ADDR_WIDTH.
  - 01/10/11: increment low 2/3/4 bits only; upper bits held (wrap-4/8/16).
- DAT_R = 0 when ACK=0. ERR=0 whenever ERRS is absent or not active.
- Reset (rstn low, any state, mid-burst included): state → IDLE, addr_cnt → 0. ACK, ERR, mem_cs, mem_we = 0, and mem_addr, mem_be, mem_wdata = 0 while rstn is low.

## Timing
- Single read or write: STB first seen in cycle N → ACK in cycle N+1. Back in IDLE at N+2; a new request presented at N+2 is ACKed at N+3.
- Read burst: ACK continuous from N+1, one beat per cycle. A beat ending with CTI=111 is the last ACK.
- Write burst: ACK continuous from N+1; each beat's DAT_W/SEL is written on its ACK edge.
- ACK is never asserted in IDLE. A combinational path exists from STB/CYC to ACK and the mem_* outputs.

## Configuration
- WB_SRAM_RANGE_ERR_EN:
  - Defined: in IDLE, a request with ADR < BASE_ADDR, or ADR ≥ BASE_ADDR + 2^MEM_ADDR_WIDTH·(WB_DATA_WIDTH/8), goes to ERRS. ERRS drives ERR=1 (gated by CYC&STB) for exactly one cycle, ACK=0, mem_cs=0, then returns to IDLE. Range is checked only at burst start; in-burst addresses follow next().
  - Undefined: no range check, addresses alias modulo SRAM size, ERR tied 0, ERRS state absent.

## Test plan
- Reset mid-burst: rstn low during an ACT read burst → ACK=0 and mem_cs=0 immediately. After release, a single read of 'h0 → ACK 1 cycle after STB.
- BASE_ADDR='h1000, single write ADR='h1008, DAT_W='hDEADBEEF, SEL='hF; then single read ADR='h1008 → write commits word 2 on ACK cycle N+1; read returns 'hDEADBEEF with ACK at N+1.
- Byte lanes: write 'h11223344 to word 5, then SEL='b0010 with DAT_W='h0000AA00 → readback 'h1122AA44.
- Linear read burst: 4 beats from word 1020, BTE=00, CTI=010×3 then 111 → ACK 4 consecutive cycles, mem_addr 1020,1021,1022,1023, no fifth access.
- Wrap-4 write burst: start word 6, BTE=01, 4 beats → writes words 6,7,4,5 in that order, then IDLE.
- With WB_SRAM_RANGE_ERR_EN, read ADR=BASE_ADDR+'h1000 (MEM_ADDR_WIDTH=10, 32-bit data) → ERR=1 one cycle, ACK=0, mem_cs=0. Without the macro → ACK, reads word 0.
